// File: rtl/lfsr_arb_pkg.sv
// Shared types and helpers for the LFSR source arbiter.
// Optional feature macro used by this slice: LFSR_ARB_PRIO0_EN.
package lfsr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

  localparam int LFSR_W_DEF = 5;
  localparam int WORD_W_DEF = 8;
  localparam int MAX_REQ    = 8;

  // One-hot inputs only; OR-reduction keeps it cheap and priority-free.
  function automatic logic [2:0] onehot2idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick starting after last_grant.
// With LFSR_ARB_PRIO0_EN, requester 0 wins outright and 1..N-1 rotate.
module rr_arbiter
  import lfsr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx
);

  logic [IDX_W-1:0] k;
  logic             found;

  always_comb begin
    pick  = '0;
    k     = '0;
    found = 1'b0;
`ifdef LFSR_ARB_PRIO0_EN
    if (req[0]) begin
      pick[0] = 1'b1;
      found   = 1'b1;
    end
`endif
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = IDX_W'((32'(last_grant) + 1 + i) % NUM_REQ);
`ifdef LFSR_ARB_PRIO0_EN
      if (!found && k != '0 && req[k]) begin
`else
      if (!found && req[k]) begin
`endif
        pick[k] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  assign pick_idx = IDX_W'(onehot2idx(MAX_REQ'(pick)));

endmodule

// File: rtl/lfsr_arbiter.sv
// Arbitrates the shared 5-bit LFSR among NUM_REQ requesters and serialises
// lfsr_q[0] into a WORD_W-bit word. Optional macro: LFSR_ARB_PRIO0_EN.
module lfsr_arbiter
  import lfsr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LFSR_W  = LFSR_W_DEF,
  parameter int WORD_W  = WORD_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQ-1:0]  req,
  input  logic [LFSR_W-1:0]   lfsr_q,
  output logic                lfsr_step,
  output logic [NUM_REQ-1:0]  grant,
  output logic [WORD_W-1:0]   word,
  output logic                word_valid,
  output logic                busy,
  output logic                lock_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(WORD_W + 1);

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] pick;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   last_grant;
  logic [CNT_W-1:0]   cnt;
  logic [WORD_W-1:0]  shreg;
  logic [WORD_W-1:0]  shift_nxt;
  logic               granted_req;
  logic               last_bit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (req),
    .last_grant (last_grant),
    .pick       (pick),
    .pick_idx   (pick_idx)
  );

  // Partial bits live in shreg so an aborted grant leaves word untouched.
  assign shift_nxt   = WORD_W'({shreg, lfsr_q[0]});
  assign granted_req = req[grant_idx];
  assign last_bit    = (cnt == CNT_W'(WORD_W - 1));

  assign lfsr_step  = (state == COLLECT);
  assign word_valid = (state == DONE);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = COLLECT;
      COLLECT: begin
        if (!granted_req)  state_nxt = IDLE;
        else if (last_bit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      grant_idx  <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      cnt        <= '0;
      shreg      <= '0;
      word       <= '0;
      lock_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (|req) begin
            grant     <= pick;
            grant_idx <= pick_idx;
            cnt       <= '0;
          end
        end
        COLLECT: begin
          shreg <= shift_nxt;
          cnt   <= cnt + 1'b1;
          if (lfsr_q == '0) lock_err <= 1'b1;
          if (!granted_req) begin
            grant      <= '0;
            last_grant <= grant_idx;
          end else if (last_bit) begin
            word <= shift_nxt;
          end
        end
        DONE: begin
          grant      <= '0;
          last_grant <= grant_idx;
        end
        default: grant <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Directed self-checking bench for lfsr_arbiter (4 requesters, 8-bit words).
module tb_lfsr_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [4:0] lfsr_q;
  logic       lfsr_step;
  logic [3:0] grant;
  logic [7:0] word;
  logic       word_valid;
  logic       busy;
  logic       lock_err;

  int tests;
  int failed;

  lfsr_arbiter #(
    .NUM_REQ (4),
    .LFSR_W  (5),
    .WORD_W  (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .lfsr_q     (lfsr_q),
    .lfsr_step  (lfsr_step),
    .grant      (grant),
    .word       (word),
    .word_valid (word_valid),
    .busy       (busy),
    .lock_err   (lock_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one grant: drives bits MSB first on step cycles, zeroes lfsr_q on step stuck_at.
  task automatic do_grant(input logic [3:0] r, input logic [7:0] bits, input int stuck_at,
                          output logic [3:0] g, output logic [7:0] w,
                          output int steps, output int lat);
    bit seen;
    seen  = 1'b0;
    steps = 0;
    lat   = 0;
    g     = '0;
    w     = '0;
    req   = r;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (word_valid) begin
        seen = 1'b1;
        g    = grant;
        w    = word;
        lat  = c;
      end else if (lfsr_step) begin
        lfsr_q = (steps == stuck_at) ? 5'b00000 : {4'b0001, bits[7 - steps]};
        steps++;
      end
    end
    if (!seen) check("grant_timeout", 32'd0, 32'd1);
    req    = '0;
    lfsr_q = 5'b00011;
  endtask

  task automatic do_reset(input logic [3:0] r);
    reset = 1'b1;
    req   = r;
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [3:0] exp_fair(input int n);
`ifdef LFSR_ARB_PRIO0_EN
    return 4'b0001;
`else
    return 4'(1 << (n % 4));
`endif
  endfunction

  initial begin
    logic [3:0] g;
    logic [7:0] w;
    int         steps, lat, nvalid, last_cyc;

    tests  = 0;
    failed = 0;
    reset  = 1'b1;
    req    = '0;
    lfsr_q = 5'b00011;

    // Reset with all requests pending
    @(negedge clk);
    do_reset(4'b1111);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_valid", 32'(word_valid), 32'h0);
    check("rst_lock", 32'(lock_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_step", 32'(lfsr_step), 32'h0);
    check("rst_word", 32'(word), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_first_grant", 32'(grant), 32'h1);
    req = '0;
    @(negedge clk);
    @(negedge clk);

    // Single word, MSB-first serialisation
    do_grant(4'b0100, 8'hB2, -1, g, w, steps, lat);
    check("sw_grant", 32'(g), 32'h4);
    check("sw_word", 32'(w), 32'hB2);
    check("sw_steps", 32'(steps), 32'd8);
    check("sw_latency", 32'(lat), 32'd9);
    @(negedge clk);
    check("sw_valid_pulse", 32'(word_valid), 32'h0);
    check("sw_grant_clr", 32'(grant), 32'h0);
    check("sw_word_hold", 32'(word), 32'hB2);

    // Fairness from a fresh reset
    do_reset(4'b1111);
    reset    = 1'b0;
    nvalid   = 0;
    last_cyc = 0;
    for (int c = 1; c <= 70 && nvalid < 5; c++) begin
      @(negedge clk);
      if (word_valid) begin
        check($sformatf("fair_grant%0d", nvalid), 32'(grant), 32'(exp_fair(nvalid)));
        check($sformatf("fair_word%0d", nvalid), 32'(word), 32'hFF);
        check($sformatf("fair_gap%0d", nvalid), 32'(c - last_cyc), (nvalid == 0) ? 32'd9 : 32'd10);
        last_cyc = c;
        nvalid++;
        if (nvalid == 5) req = '0;
      end
    end
    check("fair_count", 32'(nvalid), 32'd5);
    @(negedge clk);

    // Abort: grantee drops req in its third COLLECT cycle
    req    = 4'b0010;
    lfsr_q = 5'b00010;
    @(negedge clk);
    check("ab_grant", 32'(grant), 32'h2);
    check("ab_step_on", 32'(lfsr_step), 32'h1);
    @(negedge clk);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    check("ab_step_off", 32'(lfsr_step), 32'h0);
    check("ab_valid", 32'(word_valid), 32'h0);
    check("ab_grant_clr", 32'(grant), 32'h0);
    check("ab_word_hold", 32'(word), 32'hFF);
    check("ab_busy", 32'(busy), 32'h0);

    // Abort consumed requester 1's turn; stuck LFSR on the 4th step of this word
    do_grant(4'b0011, 8'h5A, 3, g, w, steps, lat);
    check("ab_next_grant", 32'(g), 32'h1);
    check("stuck_word", 32'(w), 32'h4A);
    check("stuck_lock", 32'(lock_err), 32'h1);
    @(negedge clk);
    do_grant(4'b1000, 8'hC3, -1, g, w, steps, lat);
    check("stuck_grant2", 32'(g), 32'h8);
    check("stuck_word2", 32'(w), 32'hC3);
    check("stuck_lock_sticky", 32'(lock_err), 32'h1);
    @(negedge clk);

`ifdef LFSR_ARB_PRIO0_EN
    do_reset(4'b0000);
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      do_grant(4'b1110, 8'h0F, -1, g, w, steps, lat);
      check($sformatf("prio_rot%0d", n), 32'(g), 32'(4'b0010 << n));
      @(negedge clk);
    end
`endif

    // Reset clears the sticky error and the word
    do_reset(4'b0000);
    check("final_lock", 32'(lock_err), 32'h0);
    check("final_word", 32'(word), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
